// File: rtl/dmi_tl_pkg.sv
// Shared types and constants for the DMI to TileLink-UL bridge.
package dmi_tl_pkg;

    typedef enum logic [1:0] {
        NOP   = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RSVD  = 2'd3
    } dmi_op_e;

    localparam logic [1:0] OK   = 2'd0;
    localparam logic [1:0] FAIL = 2'd2;

    localparam logic [2:0] GET      = 3'd4;
    localparam logic [2:0] PUT_FULL = 3'd0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        A_SEND = 3'd1,
        D_WAIT = 3'd2,
        RESP   = 3'd3,
        DRAIN  = 3'd4
    } state_e;

endpackage

// File: rtl/dmi_tl_bridge_seq.sv
// Sequential DMI request/response to single-outstanding TileLink-UL master bridge,
// with D-channel timeout and drain of a late response.
module dmi_tl_bridge_seq
    import dmi_tl_pkg::*;
#(
    parameter int                   DMI_ADDR_W = 7,
    parameter int                   DATA_W     = 32,
    parameter int                   TL_ADDR_W  = DMI_ADDR_W + 2,
    parameter logic [TL_ADDR_W-1:0] NOP_ADDR   = TL_ADDR_W'(9'h48),
    parameter bit                   NOP_PROBE  = 1'b1,
    parameter int                   TIMEOUT    = 1023
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  dmi_req_valid,
    output logic                  dmi_req_ready,
    input  logic [1:0]            dmi_req_op,
    input  logic [DMI_ADDR_W-1:0] dmi_req_addr,
    input  logic [DATA_W-1:0]     dmi_req_data,
    output logic                  dmi_resp_valid,
    input  logic                  dmi_resp_ready,
    output logic [DATA_W-1:0]     dmi_resp_data,
    output logic [1:0]            dmi_resp_status,
    output logic                  tl_a_valid,
    input  logic                  tl_a_ready,
    output logic [2:0]            tl_a_opcode,
    output logic [TL_ADDR_W-1:0]  tl_a_address,
    output logic [DATA_W-1:0]     tl_a_data,
    output logic [DATA_W/8-1:0]   tl_a_mask,
    output logic [2:0]            tl_a_size,
    input  logic                  tl_d_valid,
    output logic                  tl_d_ready,
    input  logic [DATA_W-1:0]     tl_d_data,
    input  logic                  tl_d_denied,
    input  logic                  tl_d_corrupt
);

    localparam int              CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    state_e                 state_reg;
    logic                   a_valid_reg;
    logic [2:0]             a_opcode_reg;
    logic [TL_ADDR_W-1:0]   a_addr_reg;
    logic [DATA_W-1:0]      a_data_reg;
    logic                   d_ready_reg;
    logic                   resp_valid_reg;
    logic [DATA_W-1:0]      resp_data_reg;
    logic [1:0]             resp_status_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   drain_reg;

    dmi_op_e                req_op;
    logic                   start_tl;
    logic [TL_ADDR_W-1:0]   req_byte_addr;

    assign req_op   = dmi_op_e'(dmi_req_op);
    assign start_tl = (req_op == READ) || (req_op == WRITE) || ((req_op == NOP) && NOP_PROBE);

    always_comb begin
        req_byte_addr = '0;
        req_byte_addr[DMI_ADDR_W+1:0] = {dmi_req_addr, 2'b00};
    end

    // Ready is gated by reset so nothing is accepted while the fabric is held in reset.
    assign dmi_req_ready   = (state_reg == IDLE) && !reset;
    assign dmi_resp_valid  = resp_valid_reg;
    assign dmi_resp_data   = resp_data_reg;
    assign dmi_resp_status = resp_status_reg;
    assign tl_a_valid      = a_valid_reg;
    assign tl_a_opcode     = a_opcode_reg;
    assign tl_a_address    = a_addr_reg;
    assign tl_a_data       = a_data_reg;
    assign tl_a_mask       = '1;
    assign tl_a_size       = 3'($clog2(DATA_W / 8));
    assign tl_d_ready      = d_ready_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            a_valid_reg     <= 1'b0;
            a_opcode_reg    <= '0;
            a_addr_reg      <= '0;
            a_data_reg      <= '0;
            d_ready_reg     <= 1'b0;
            resp_valid_reg  <= 1'b0;
            resp_data_reg   <= '0;
            resp_status_reg <= '0;
            cnt_reg         <= '0;
            drain_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (dmi_req_valid) begin
                        if (start_tl) begin
                            a_opcode_reg <= (req_op == WRITE) ? PUT_FULL : GET;
                            a_addr_reg   <= (req_op == NOP) ? NOP_ADDR : req_byte_addr;
                            a_data_reg   <= (req_op == WRITE) ? dmi_req_data : '0;
                            a_valid_reg  <= 1'b1;
                            state_reg    <= A_SEND;
                        end else begin
                            resp_status_reg <= (req_op == RSVD) ? FAIL : OK;
                            resp_data_reg   <= '0;
                            resp_valid_reg  <= 1'b1;
                            state_reg       <= RESP;
                        end
                    end
                end
                A_SEND: begin
                    if (tl_a_ready) begin
                        a_valid_reg <= 1'b0;
                        d_ready_reg <= 1'b1;
                        cnt_reg     <= '0;
                        state_reg   <= D_WAIT;
                    end
                end
                D_WAIT: begin
                    if (tl_d_valid) begin
                        resp_status_reg <= (tl_d_denied || tl_d_corrupt) ? FAIL : OK;
                        resp_data_reg   <= (a_opcode_reg == GET) ? tl_d_data : '0;
                        d_ready_reg     <= 1'b0;
                        resp_valid_reg  <= 1'b1;
                        state_reg       <= RESP;
                    end else if (TIMEOUT != 0) begin
                        // Counter stops at TIMEOUT because the state is left on that same edge.
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == CNT_LAST) begin
                            resp_status_reg <= FAIL;
                            resp_data_reg   <= '0;
                            d_ready_reg     <= 1'b0;
                            resp_valid_reg  <= 1'b1;
                            drain_reg       <= 1'b1;
                            state_reg       <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (dmi_resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        if (drain_reg) begin
                            d_ready_reg <= 1'b1;
                            state_reg   <= DRAIN;
                        end else begin
                            state_reg   <= IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (tl_d_valid) begin
                        d_ready_reg <= 1'b0;
                        drain_reg   <= 1'b0;
                        state_reg   <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmi_tl_bridge_seq.sv
// Self-checking bench: directed vector table, randomized transactions against a
// spec-level model, and hand sequences for timeout/drain and mid-operation reset.
module tb_dmi_tl_bridge_seq;

    logic        clock;
    logic        reset;
    logic        dmi_req_valid;
    logic        dmi_req_ready;
    logic [1:0]  dmi_req_op;
    logic [6:0]  dmi_req_addr;
    logic [31:0] dmi_req_data;
    logic        dmi_resp_valid;
    logic        dmi_resp_ready;
    logic [31:0] dmi_resp_data;
    logic [1:0]  dmi_resp_status;
    logic        tl_a_valid;
    logic        tl_a_ready;
    logic [2:0]  tl_a_opcode;
    logic [8:0]  tl_a_address;
    logic [31:0] tl_a_data;
    logic [3:0]  tl_a_mask;
    logic [2:0]  tl_a_size;
    logic        tl_d_valid;
    logic        tl_d_ready;
    logic [31:0] tl_d_data;
    logic        tl_d_denied;
    logic        tl_d_corrupt;

    int n_cmp = 0;
    int n_err = 0;

    dmi_tl_bridge_seq #(
        .DMI_ADDR_W (7),
        .DATA_W     (32),
        .TL_ADDR_W  (9),
        .NOP_ADDR   (9'h48),
        .NOP_PROBE  (1'b1),
        .TIMEOUT    (8)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .dmi_req_valid   (dmi_req_valid),
        .dmi_req_ready   (dmi_req_ready),
        .dmi_req_op      (dmi_req_op),
        .dmi_req_addr    (dmi_req_addr),
        .dmi_req_data    (dmi_req_data),
        .dmi_resp_valid  (dmi_resp_valid),
        .dmi_resp_ready  (dmi_resp_ready),
        .dmi_resp_data   (dmi_resp_data),
        .dmi_resp_status (dmi_resp_status),
        .tl_a_valid      (tl_a_valid),
        .tl_a_ready      (tl_a_ready),
        .tl_a_opcode     (tl_a_opcode),
        .tl_a_address    (tl_a_address),
        .tl_a_data       (tl_a_data),
        .tl_a_mask       (tl_a_mask),
        .tl_a_size       (tl_a_size),
        .tl_d_valid      (tl_d_valid),
        .tl_d_ready      (tl_d_ready),
        .tl_d_data       (tl_d_data),
        .tl_d_denied     (tl_d_denied),
        .tl_d_corrupt    (tl_d_corrupt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  op;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          den;
        bit          cor;
        int          a_wait;
        int          d_wait;
        int          r_wait;
        bit          exp_issue;
        logic [2:0]  exp_opcode;
        logic [8:0]  exp_addr;
        logic [31:0] exp_adata;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_status;
    } vec_t;

    vec_t dir_tbl[6];
    vec_t v;
    int   cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference behaviour from the bridge rules: reserved ops never reach TL,
    // addresses are word address times four, nops probe 0x48, writes return zero data.
    function automatic vec_t model(input vec_t i);
        vec_t r;
        r = i;
        r.exp_issue  = (i.op != 2'd3);
        r.exp_opcode = (i.op == 2'd2) ? 3'd0 : 3'd4;
        r.exp_addr   = (i.op == 2'd0) ? 9'h48 : 9'(int'(i.addr) * 4);
        r.exp_adata  = (i.op == 2'd2) ? i.wdata : 32'h0;
        if (i.op == 2'd3) begin
            r.exp_rdata  = 32'h0;
            r.exp_status = 2'd2;
        end else begin
            r.exp_rdata  = (i.op == 2'd2) ? 32'h0 : i.rdata;
            r.exp_status = (i.den || i.cor) ? 2'd2 : 2'd0;
        end
        return r;
    endfunction

    // Starts and ends on a falling edge with all bench-driven handshakes idle.
    task automatic run_txn(input vec_t t, input string tag);
        int lat;
        int w;
        int exp_lat;
        w = 0;
        while (!dmi_req_ready && w < 20) begin
            @(negedge clock);
            w++;
        end
        check({tag, " req_ready"}, 64'(dmi_req_ready), 64'(1));
        dmi_req_valid = 1'b1;
        dmi_req_op    = t.op;
        dmi_req_addr  = t.addr;
        dmi_req_data  = t.wdata;
        @(negedge clock);
        dmi_req_valid = 1'b0;
        dmi_req_data  = $urandom;
        lat = 1;
        if (t.exp_issue) begin
            for (int i = 0; i <= t.a_wait; i++) begin
                check({tag, " a_valid"}, 64'(tl_a_valid), 64'(1));
                check({tag, " a_payload"},
                      64'({tl_a_opcode, tl_a_address, tl_a_data, tl_a_mask, tl_a_size}),
                      64'({t.exp_opcode, t.exp_addr, t.exp_adata, 4'hF, 3'd2}));
                if (i == t.a_wait) tl_a_ready = 1'b1;
                @(negedge clock);
                lat++;
            end
            tl_a_ready = 1'b0;
            check({tag, " a_valid_drop"}, 64'(tl_a_valid), 64'(0));
            for (int i = 0; i <= t.d_wait; i++) begin
                check({tag, " d_ready"}, 64'(tl_d_ready), 64'(1));
                check({tag, " early_resp"}, 64'(dmi_resp_valid), 64'(0));
                if (i == t.d_wait) begin
                    tl_d_valid   = 1'b1;
                    tl_d_data    = t.rdata;
                    tl_d_denied  = t.den;
                    tl_d_corrupt = t.cor;
                end
                @(negedge clock);
                lat++;
            end
            tl_d_valid   = 1'b0;
            tl_d_denied  = 1'b0;
            tl_d_corrupt = 1'b0;
            tl_d_data    = $urandom;
        end
        while (!dmi_resp_valid && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        exp_lat = t.exp_issue ? (3 + t.a_wait + t.d_wait) : 1;
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        for (int i = 0; i <= t.r_wait; i++) begin
            check({tag, " resp_valid"}, 64'(dmi_resp_valid), 64'(1));
            check({tag, " resp"}, 64'({dmi_resp_data, dmi_resp_status}),
                  64'({t.exp_rdata, t.exp_status}));
            check({tag, " ready_in_resp"}, 64'(dmi_req_ready), 64'(0));
            check({tag, " a_in_resp"}, 64'({tl_a_valid, tl_d_ready}), 64'(0));
            if (i == t.r_wait) dmi_resp_ready = 1'b1;
            @(negedge clock);
        end
        dmi_resp_ready = 1'b0;
        check({tag, " resp_done"}, 64'({dmi_resp_valid, dmi_req_ready}), 64'(2'b01));
        $display("txn %s op=%0d addr=%h data=%h status=%0d lat=%0d",
                 tag, t.op, t.addr, dmi_resp_data, dmi_resp_status, lat);
    endtask

    initial begin
        reset          = 1'b1;
        dmi_req_valid  = 1'b0;
        dmi_req_op     = 2'd0;
        dmi_req_addr   = 7'h0;
        dmi_req_data   = 32'h0;
        dmi_resp_ready = 1'b0;
        tl_a_ready     = 1'b0;
        tl_d_valid     = 1'b0;
        tl_d_data      = 32'h0;
        tl_d_denied    = 1'b0;
        tl_d_corrupt   = 1'b0;

        //                op     addr    wdata         rdata         den   cor   aw dw rw iss   opc   addr     adata         resp          st
        dir_tbl[0] = '{2'd1, 7'h11, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 0, 0, 0, 1'b1, 3'd4, 9'h044, 32'h0,        32'hDEADBEEF, 2'd0};
        dir_tbl[1] = '{2'd2, 7'h10, 32'h1,        32'hCAFEF00D, 1'b0, 1'b0, 0, 1, 0, 1'b1, 3'd0, 9'h040, 32'h1,        32'h0,        2'd0};
        dir_tbl[2] = '{2'd0, 7'h05, 32'h1234,     32'h0BADF00D, 1'b0, 1'b0, 1, 0, 0, 1'b1, 3'd4, 9'h048, 32'h0,        32'h0BADF00D, 2'd0};
        dir_tbl[3] = '{2'd3, 7'h22, 32'hFFFF,     32'h5555,     1'b0, 1'b0, 0, 0, 1, 1'b0, 3'd4, 9'h000, 32'h0,        32'h0,        2'd2};
        dir_tbl[4] = '{2'd1, 7'h7F, 32'h0,        32'h87654321, 1'b1, 1'b0, 5, 2, 3, 1'b1, 3'd4, 9'h1FC, 32'h0,        32'h87654321, 2'd2};
        dir_tbl[5] = '{2'd2, 7'h03, 32'hA5A5A5A5, 32'h1111,     1'b0, 1'b1, 2, 3, 1, 1'b1, 3'd0, 9'h00C, 32'hA5A5A5A5, 32'h0,        2'd2};

        repeat (3) @(negedge clock);
        check("rst ready", 64'(dmi_req_ready), 64'(0));
        check("rst valids", 64'({tl_a_valid, tl_d_ready, dmi_resp_valid}), 64'(0));
        check("rst resp", 64'({dmi_resp_data, dmi_resp_status}), 64'(0));
        check("rst a_payload", 64'({tl_a_opcode, tl_a_address, tl_a_data}), 64'(0));
        tl_d_valid = 1'b1;
        reset = 1'b0;
        #1;
        check("idle ready", 64'(dmi_req_ready), 64'(1));
        check("idle d_ready", 64'(tl_d_ready), 64'(0));
        @(negedge clock);
        check("stray d ignored", 64'({dmi_req_ready, dmi_resp_valid, tl_d_ready}), 64'(3'b100));
        tl_d_valid = 1'b0;

        for (int i = 0; i < 6; i++) run_txn(dir_tbl[i], $sformatf("dir%0d", i));

        for (int k = 0; k < 40; k++) begin
            v.op     = 2'($urandom_range(0, 3));
            v.addr   = 7'($urandom);
            v.wdata  = $urandom;
            v.rdata  = $urandom;
            v.den    = ($urandom_range(0, 7) == 0);
            v.cor    = ($urandom_range(0, 7) == 0);
            v.a_wait = int'($urandom_range(0, 3));
            v.d_wait = int'($urandom_range(0, 4));
            v.r_wait = int'($urandom_range(0, 2));
            v = model(v);
            run_txn(v, $sformatf("rnd%0d", k));
        end

        // Timeout: no D beat ever arrives for this read.
        dmi_req_valid = 1'b1;
        dmi_req_op    = 2'd1;
        dmi_req_addr  = 7'h2A;
        @(negedge clock);
        dmi_req_valid = 1'b0;
        check("to a_valid", 64'(tl_a_valid), 64'(1));
        tl_a_ready = 1'b1;
        @(negedge clock);
        tl_a_ready = 1'b0;
        cnt = 0;
        while (!dmi_resp_valid && cnt < 30) begin
            if (tl_d_ready) cnt++;
            @(negedge clock);
        end
        check("to d_wait cycles", 64'(cnt), 64'(8));
        check("to resp", 64'({dmi_resp_valid, dmi_resp_data, dmi_resp_status}),
              64'({1'b1, 32'h0, 2'd2}));
        dmi_resp_ready = 1'b1;
        @(negedge clock);
        dmi_resp_ready = 1'b0;
        dmi_req_valid  = 1'b1;
        dmi_req_op     = 2'd2;
        for (int i = 0; i < 4; i++) begin
            check("drain ready", 64'(dmi_req_ready), 64'(0));
            check("drain d_ready", 64'({tl_d_ready, dmi_resp_valid, tl_a_valid}), 64'(3'b100));
            @(negedge clock);
        end
        dmi_req_valid = 1'b0;
        tl_d_valid    = 1'b1;
        tl_d_data     = 32'h13579BDF;
        @(negedge clock);
        tl_d_valid = 1'b0;
        check("drain done", 64'({dmi_req_ready, tl_d_ready, dmi_resp_valid}), 64'(3'b100));
        $display("txn timeout_drain cycles=%0d", cnt);
        v = '{2'd1, 7'h11, 32'h0, 32'h2468ACE0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 3'd0, 9'h0, 32'h0, 32'h0, 2'd0};
        run_txn(model(v), "post_drain");

        // Reset while the A beat is waiting for ready.
        dmi_req_valid = 1'b1;
        dmi_req_op    = 2'd1;
        dmi_req_addr  = 7'h33;
        @(negedge clock);
        dmi_req_valid = 1'b0;
        check("mid a_valid", 64'(tl_a_valid), 64'(1));
        reset = 1'b1;
        @(negedge clock);
        check("mid rst ready", 64'(dmi_req_ready), 64'(0));
        reset = 1'b0;
        #1;
        check("mid rst after", 64'({dmi_req_ready, tl_a_valid, tl_d_ready, dmi_resp_valid}),
              64'(4'b1000));
        @(negedge clock);
        $display("txn mid_reset ready=%0d", dmi_req_ready);
        v = '{2'd2, 7'h44, 32'h0F0F0F0F, 32'h0, 1'b0, 1'b0, 1, 1, 1, 1'b0, 3'd0, 9'h0, 32'h0, 32'h0, 2'd0};
        run_txn(model(v), "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
